mc_fir_decim: RTL



---
 rtl/fir_pkg.sv | 54 +++++
 rtl/fir_coeff_bank.sv | 52 +++++
 rtl/mc_fir_decim.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the multi-channel decimating FIR.
package fir_pkg;

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    typedef struct packed {
        logic        sat;
        logic [63:0] value;
    } round_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

    // Round half-up, arithmetic shift, then clip to a signed ow-bit range.
    function automatic round_t round_sat(input logic signed [63:0] acc, input int shift,
                                         input int ow);
        round_t res;
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = acc;
        if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
        v  = v >>> shift;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        res.sat   = 1'b0;
        res.value = v;
        if (v > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (v < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: writes go to the shadow bank, a swap
// request is held pending until the filter is idle.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int NUM_TAPS    = 32,
    parameter int COEFF_WIDTH = 18,
    localparam int PTR_W      = (clog2(NUM_TAPS) > 0) ? clog2(NUM_TAPS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [COEFF_WIDTH-1:0] wr_data,
    input  logic [7:0]                    wr_addr,
    input  logic                          wr_en,
    input  logic                          ld,
    input  logic                          idle,
    input  logic [PTR_W-1:0]              rd_tap,
    output logic signed [COEFF_WIDTH-1:0] rd_coef,
    output logic                          pending
);

    logic signed [COEFF_WIDTH-1:0] bank [2][NUM_TAPS];
    logic                          active;
    logic                          swap;

    assign swap    = idle && pending;
    assign rd_coef = bank[active][rd_tap];

    // NOTE: these banks are registers, not RAM, so resetting every entry is
    // cheap and guarantees a zero filter until software loads one.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            pending <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < NUM_TAPS; k++)
                    bank[b][k] <= '0;
        end else begin
            // NOTE: non-blocking reads of 'active' mean a write on the swap
            // edge still lands in the bank that is about to become active.
            if (wr_en && (int'(wr_addr) < NUM_TAPS))
                bank[~active][wr_addr[PTR_W-1:0]] <= wr_data;
            if (swap) begin
                active  <= ~active;
                pending <= 1'b0;
            end else if (ld) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_fir_decim.sv
// Time-multiplexed multi-channel FIR with decimation: one serial MAC shared
// by all channels, per-channel circular history, round and saturate.
module mc_fir_decim
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int COEFF_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 18,
    parameter int NUM_TAPS     = 32,
    parameter int NUM_CH       = 4,
    parameter int DECIM        = 1,
    parameter int OUT_SHIFT    = 17,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    input  logic [CH_W-1:0]                in_ch,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]                out_ch,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic signed [COEFF_WIDTH-1:0]  coeff_data,
    input  logic [7:0]                     coeff_addr,
    input  logic                           coeff_wr,
    input  logic                           coeff_ld,
    output logic                           coeff_pending,
    output logic [15:0]                    sat_count
);

    localparam int PTR_W  = (clog2(NUM_TAPS) > 0) ? clog2(NUM_TAPS) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int PH_W   = (clog2(DECIM) > 0) ? clog2(DECIM) : 1;
    localparam int DEPTH  = NUM_CH * NUM_TAPS;
    localparam int ADDR_W = clog2(DEPTH);
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    logic [2:0]                    state;
    logic [ADDR_W-1:0]             clr_cnt;
    logic [PTR_W-1:0]              wptr  [NUM_CH];
    logic [PH_W-1:0]               phase [NUM_CH];
    logic [CH_W-1:0]               cur_ch;
    logic [PTR_W-1:0]              cur_ptr;
    logic [CNT_W-1:0]              tap;
    logic [PTR_W-1:0]              rd_tap;
    logic                          rd_vld;
    logic signed [DATA_WIDTH-1:0]  rd_data;
    logic signed [COEFF_WIDTH-1:0] coef;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       acc;
    round_t                        rs;
    logic                          ch_ok;
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic signed [DATA_WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0]             rd_addr;

    logic signed [DATA_WIDTH-1:0]  ring [DEPTH];

    assign in_ready = (state == ST_IDLE);
    assign ch_ok    = int'(in_ch) < NUM_CH;
    assign prod     = PROD_W'(rd_data) * PROD_W'(coef);
    assign rs       = round_sat(64'(acc), OUT_SHIFT, OUTPUT_WIDTH);

    fir_coeff_bank #(
        .NUM_TAPS    (NUM_TAPS),
        .COEFF_WIDTH (COEFF_WIDTH)
    ) u_coeff (
        .clk     (clk),
        .rst     (rst),
        .wr_data (coeff_data),
        .wr_addr (coeff_addr),
        .wr_en   (coeff_wr),
        .ld      (coeff_ld),
        .idle    (in_ready),
        .rd_tap  (rd_tap),
        .rd_coef (coef),
        .pending (coeff_pending)
    );

    // Single write port shared by the clear sweep and sample acceptance.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
            end else if (in_ready && in_valid && ch_ok) begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(int'(in_ch) * NUM_TAPS + int'(wptr[in_ch]));
                wr_data = in_data;
            end
        end
    end

    // Tap k reads x[n-k], walking backwards from the newest sample.
    always_comb begin
        int idx;
        idx = int'(cur_ptr) - int'(tap);
        if (idx < 0) idx = idx + NUM_TAPS;
        rd_addr = ADDR_W'(int'(cur_ch) * NUM_TAPS + idx);
    end

    // NOTE: the history RAM has no reset so it maps to block RAM; the CLEAR
    // sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) ring[wr_addr] <= wr_data;
        rd_data <= ring[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            cur_ch    <= '0;
            cur_ptr   <= '0;
            tap       <= '0;
            rd_tap    <= '0;
            rd_vld    <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sat_count <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c]  <= '0;
                phase[c] <= '0;
            end
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (int'(clr_cnt) == DEPTH - 1) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (in_valid && ch_ok) begin
                        wptr[in_ch]  <= (int'(wptr[in_ch]) == NUM_TAPS - 1) ? '0 : wptr[in_ch] + 1'b1;
                        phase[in_ch] <= (int'(phase[in_ch]) == DECIM - 1) ? '0 : phase[in_ch] + 1'b1;
                        if (phase[in_ch] == '0) begin
                            state   <= ST_MAC;
                            cur_ch  <= in_ch;
                            cur_ptr <= wptr[in_ch];
                            tap     <= '0;
                            rd_vld  <= 1'b0;
                            acc     <= '0;
                        end
                    end
                end
                ST_MAC: begin
                    if (int'(tap) < NUM_TAPS) begin
                        rd_tap <= tap[PTR_W-1:0];
                        tap    <= tap + 1'b1;
                        rd_vld <= 1'b1;
                    end else begin
                        rd_vld <= 1'b0;
                    end
                    if (rd_vld) begin
                        acc <= acc + ACC_W'(prod);
                        if (int'(rd_tap) == NUM_TAPS - 1) state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    out_data  <= rs.value[OUTPUT_WIDTH-1:0];
                    out_ch    <= cur_ch;
                    out_valid <= 1'b1;
                    if (rs.sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule
